// File: rtl/cia_timer_bank.sv
`default_nettype none
// ============================================================================
//  Module   : cia_timer_bank
//  Purpose  : Bank of NUM_TIMERS down-counting interval timers on the CIA-style
//             phi2-strobed register bus. The timers support one-shot mode,
//             reload, chaining, per-timer pulse/toggle outputs and a masked
//             interrupt register.
//  Revision : 1.0  initial release
// ============================================================================
module cia_timer_bank #(
    parameter int NUM_TIMERS = 4,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  phi2_p,
    input  logic                  phi2_n,
    input  logic                  cs_n,
    input  logic                  rw,
    input  logic [5:0]            rs,
    input  logic [7:0]            db_in,
    output logic [7:0]            db_out,
    input  logic                  cnt_in,
    output logic [NUM_TIMERS-1:0] tmr_out,
    output logic                  irq_n
);

    localparam int               c_B   = WIDTH / 8;
    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [5:0]       c_ICR = 6'h38;
    localparam logic [5:0]       c_IMR = 6'h39;

    // Per-timer state
    logic [WIDTH-1:0]      r_latch [NUM_TIMERS];
    logic [WIDTH-1:0]      r_cnt   [NUM_TIMERS];
    logic [1:0]            r_src   [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] r_start;
    logic [NUM_TIMERS-1:0] r_out_en;
    logic [NUM_TIMERS-1:0] r_toggle;
    logic [NUM_TIMERS-1:0] r_oneshot;
    logic [NUM_TIMERS-1:0] r_fload;
    logic [NUM_TIMERS-1:0] r_tff;
    logic [NUM_TIMERS-1:0] r_pulse;

    // Shared interrupt / bus state
    logic [NUM_TIMERS-1:0] r_flags;
    logic [NUM_TIMERS-1:0] r_mask;
    logic                  r_irq_n;
    logic                  r_icr_clr;
    logic                  r_cnt_prev;
    logic                  r_cnt_pend;
    logic [7:0]            r_db_out;

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_cnt_evt;
    logic [NUM_TIMERS-1:0] w_sel;
    logic [NUM_TIMERS-1:0] w_evt;
    logic [NUM_TIMERS-1:0] w_uf;
    logic [NUM_TIMERS-1:0] w_flags_next;
    logic                  w_irq_n_next;
    logic [WIDTH-1:0]      w_latch_new [NUM_TIMERS];
    logic [7:0]            w_rd_data;

    assign w_rd      = phi2_n & ~cs_n & rw;
    assign w_wr      = phi2_n & ~cs_n & ~rw;
    // An edge seen on the phi2_p clk itself still counts on that strobe
    assign w_cnt_evt = r_cnt_pend | (cnt_in & ~r_cnt_prev);
    assign db_out    = r_db_out;
    assign irq_n     = r_irq_n;

    // Timer-slot decode and merged latch value after any byte write this clk
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            w_sel[i]       = (rs[5:3] == 3'(i));
            w_latch_new[i] = r_latch[i];
            if (w_wr && w_sel[i]) begin
                for (int b = 0; b < c_B; b++) begin
                    if (rs[2:0] == 3'(b)) begin
                        w_latch_new[i][8*b +: 8] = db_in;
                    end
                end
            end
        end
    end

    // Count events and underflows; the chain ripples through all timers in one strobe
    always_comb begin
        logic w_chain;
        w_chain = 1'b0;
        w_evt   = '0;
        w_uf    = '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            case (r_src[i])
                2'b00:   w_evt[i] = 1'b1;
                2'b01:   w_evt[i] = w_cnt_evt;
                2'b10:   w_evt[i] = w_chain;
                default: w_evt[i] = w_chain & cnt_in;
            endcase
            w_evt[i] = w_evt[i] & r_start[i] & phi2_p;
            w_uf[i]  = w_evt[i] & ~r_fload[i] & (r_cnt[i] == '0);
            w_chain  = w_uf[i];
        end
    end

    // Interrupt flag update: a pending ICR clear releases irq_n, a new underflow still sets its flag
    always_comb begin
        w_flags_next = (r_icr_clr ? '0 : r_flags) | w_uf;
        w_irq_n_next = r_icr_clr | ~(~r_irq_n | (|(w_flags_next & r_mask)));
    end

    // Timer outputs: pulse for one phi2 after underflow, or the toggle flip-flop
    always_comb begin
        for (int i = 0; i < NUM_TIMERS; i++) begin
            tmr_out[i] = r_out_en[i] & (r_toggle[i] ? r_tff[i] : r_pulse[i]);
        end
    end

    // Read-data multiplexer
    always_comb begin
        w_rd_data = 8'h00;
        if (rs == c_ICR) begin
            w_rd_data    = 8'(r_flags);
            w_rd_data[7] = ~r_irq_n;
        end else if (rs == c_IMR) begin
            w_rd_data = 8'(r_mask);
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_sel[i]) begin
                    if (rs[2:0] == 3'd4) begin
                        w_rd_data = {1'b0, r_src[i], 1'b0, r_oneshot[i],
                                     r_toggle[i], r_out_en[i], r_start[i]};
                    end else begin
                        for (int b = 0; b < c_B; b++) begin
                            if (rs[2:0] == 3'(b)) begin
                                w_rd_data = r_cnt[i][8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    // All registered state: counting on phi2_p, bus accesses on phi2_n
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_latch[i] <= '1;
                r_cnt[i]   <= '0;
                r_src[i]   <= 2'b00;
            end
            r_start    <= '0;
            r_out_en   <= '0;
            r_toggle   <= '0;
            r_oneshot  <= '0;
            r_fload    <= '0;
            r_tff      <= '0;
            r_pulse    <= '0;
            r_flags    <= '0;
            r_mask     <= '0;
            r_irq_n    <= 1'b1;
            r_icr_clr  <= 1'b0;
            r_cnt_prev <= cnt_in;
            r_cnt_pend <= 1'b0;
            r_db_out   <= 8'h00;
        end else begin
            r_cnt_prev <= cnt_in;
            if (phi2_p) begin
                r_cnt_pend <= 1'b0;
            end else if (cnt_in & ~r_cnt_prev) begin
                r_cnt_pend <= 1'b1;
            end

            for (int i = 0; i < NUM_TIMERS; i++) begin
                r_latch[i] <= w_latch_new[i];
            end

            if (phi2_p) begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (r_fload[i] || w_uf[i]) begin
                        r_cnt[i] <= r_latch[i];
                    end else if (w_evt[i]) begin
                        r_cnt[i] <= r_cnt[i] - c_ONE;
                    end
                    if (w_uf[i]) begin
                        r_tff[i] <= ~r_tff[i];
                        if (r_oneshot[i]) begin
                            r_start[i] <= 1'b0;
                        end
                    end
                end
                r_fload   <= '0;
                r_pulse   <= w_uf;
                r_flags   <= w_flags_next;
                r_irq_n   <= w_irq_n_next;
                r_icr_clr <= 1'b0;
            end

            if (w_rd) begin
                r_db_out <= w_rd_data;
                if (rs == c_ICR) begin
                    r_icr_clr <= 1'b1;
                end
            end

            if (w_wr) begin
                if (rs == c_ICR) begin
                    if (db_in[7]) begin
                        r_mask <= r_mask | db_in[NUM_TIMERS-1:0];
                    end else begin
                        r_mask <= r_mask & ~db_in[NUM_TIMERS-1:0];
                    end
                end
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (w_sel[i]) begin
                        if (rs[2:0] == 3'd4) begin
                            r_start[i]   <= db_in[0];
                            r_out_en[i]  <= db_in[1];
                            r_toggle[i]  <= db_in[2];
                            r_oneshot[i] <= db_in[3];
                            r_src[i]     <= db_in[6:5];
                            if (db_in[0] & ~r_start[i]) begin
                                r_tff[i] <= 1'b1;
                            end
                            if (db_in[4]) begin
                                r_fload[i] <= 1'b1;
                            end
                        end
                        // Top-byte write on a stopped timer also primes the counter
                        if ((rs[2:0] == 3'(c_B - 1)) && !r_start[i]) begin
                            r_cnt[i] <= w_latch_new[i];
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cia_timer_bank.md
# cia_timer_bank

Parametrised interval-timer bank for the C64 core's peripheral layer. It generalises the CIA timer pair to `NUM_TIMERS` timers of `WIDTH` bits each. Every timer can count, one-shot, reload and chain to the timer below it. Timer underflows drive per-timer outputs and feed a CIA-style masked interrupt register. The block sits on the same phi2-strobed register bus as the CIAs and shares their access semantics.

## Interface
- `NUM_TIMERS`, default 4: number of timers, 1..7.
- `WIDTH`, default 16: timer width in bits, one of 8/16/24/32. The byte count is B = WIDTH/8.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `phi2_p`  in  1  one-clk strobe at the phi2 rising edge. All counting happens on this strobe.
- `phi2_n`  in  1  one-clk strobe at the phi2 falling edge. All bus accesses happen on this strobe.
- `cs_n`  in  1  chip select, active low.
- `rw`  in  1  1 = read, 0 = write.
- `rs`  in  6  register address.
- `db_in`  in  8  write data.
- `db_out`  out  8  registered read data.
- `cnt_in`  in  1  external count input. Its rising edges are detected on `clk`.
- `tmr_out`  out  NUM_TIMERS  per-timer pulse/toggle outputs.
- `irq_n`  out  1  interrupt request, active low.

## Operation
- Bus strobes:
  - rd = phi2_n & !cs_n & rw.
  - wr = phi2_n & !cs_n & !rw.
- Register map:
  - Timer i occupies rs = 8i+k.
  - k = 0..B-1: byte k of the timer. A write sets byte k of the latch. A read returns byte k of the live counter.
  - k = B..3 and k = 5..7: read 0, writes ignored.
  - k = 4: CTRL.
  - rs = 0x38: ICR. A read returns {irq_active, 0…, flags[NUM_TIMERS-1:0]}. A write sets the mask: if bit7 = 1, mask |= bits; otherwise mask &= ~bits.
  - rs = 0x39: mask readback.
  - All other addresses read 0.
- CTRL bits:
  - [0] START.
  - [1] OUT_EN.
  - [2] TOGGLE (0 = pulse mode).
  - [3] ONESHOT.
  - [4] FORCE_LOAD. This is a strobe and always reads 0.
  - [6:5] SRC:
    - 00: every phi2.
    - 01: `cnt_in` rising edge.
    - 10: underflow of timer i-1.
    - 11: underflow of timer i-1 while `cnt_in` = 1.
    - For timer 0, SRC = 1x never counts.
  - [7] reads 0.
- Count event: START = 1 and the SRC condition is true at a phi2_p.
  - Counter ≠ 0: the counter decrements.
  - Counter = 0: underflow. The counter reloads from the latch, flag i sets, and the toggle flip-flop inverts. If ONESHOT = 1, START clears.
  - Period = latch + 1 events.
  - Latch = 0 gives an underflow on every event.
- Chaining is combinational within the phi2_p. Timer i's underflow counts timer i+1 on the same phi2_p, so an N-deep cascade resolves in one phi2.
- Writing the top byte (k = B-1) while START = 0 also loads the counter from the new latch value.
- FORCE_LOAD loads the counter from the latch at the next phi2_p. This load takes priority over a decrement on that edge. No underflow is generated by a force load.
- A CTRL write with START going 0→1 sets the toggle flip-flop to 1.
- `tmr_out[i]`:
  - OUT_EN = 0: output is 0.
  - Pulse mode: output is 1 for exactly the phi2 cycle following an underflow.
  - Toggle mode: output equals the toggle flip-flop.
- Interrupts:
  - `irq_n` goes low at the phi2_p after which (flags & mask) ≠ 0.
  - It stays low until an ICR read.
  - An ICR read clears all flags and releases `irq_n` at the next phi2_p.
  - If an underflow lands on that same phi2_p, set wins: the flag stays 1, and `irq_n` re-asserts at the following phi2_p if that flag is masked on.
  - A mask change takes effect at the next phi2_p.

## Timing
- Reset values:
  - all latches all-ones.
  - counters 0.
  - CTRL 0.
  - flags 0, mask 0.
  - `irq_n` = 1.
  - `db_out` = 0.
  - `tmr_out` = 0.
  - edge detector primed from `cnt_in`.
- `reset` overrides everything, including an in-flight count, a pending FORCE_LOAD and a pending ICR clear. Nothing survives reset.
- `db_out` updates on the clk following an rd cycle and holds otherwise.
- Start latency: a CTRL write with START = 1 on phi2_n makes the first eligible count the next phi2_p.
- A `cnt_in` edge counts at the first phi2_p after the edge. Multiple edges between two phi2_p count once.
- A latch write on the same phi2 as an underflow: the reload uses the already-written latch bytes. The written byte lands before the next phi2_p.
- Counter arithmetic is modulo 2^WIDTH. Only the zero-detect triggers underflow, so no wrap past 0 is ever visible.

## Test plan
- Free-run: WIDTH = 16, latch 0x0003, CTRL = 0x03 (START + OUT_EN, pulse, phi2 source).
  - Required: counter reads 3, 2, 1, 0, 3…
  - `tmr_out[0]` pulses every 4 phi2.
  - flag0 sets every 4 phi2.
- One-shot + IRQ: mask 0x81, latch 5, CTRL = 0x09.
  - Required: `irq_n` low after 6 phi2, START reads 0, counter = 5.
  - ICR read returns 0x81; the next phi2_p releases `irq_n`.
- Chain: NUM_TIMERS = 3, T0 latch 1, T1 latch 2 with SRC = 10, T2 latch 0 with SRC = 10, all started.
  - Required: T1 underflows every 6 phi2.
  - T2 underflows every 6 phi2, on the same phi2_p as T1.
- Toggle/cnt: T0 SRC = 01, TOGGLE, latch 0.
  - Stimulus: 4 `cnt_in` pulses.
  - Required: `tmr_out[0]` sequence 1→0→1→0→1.
  - Two edges inside one phi2 count once.
- Collision: an ICR read on the phi2 where T0 underflows, mask 0x81.
  - Required: flag0 stays 1 and `irq_n` is low again one phi2 later.
  - Force-load plus a stopped top-byte write loads the counter correctly. A `reset` mid-count restores all reset values.
